// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_WIDTH = 32;

  localparam logic [XLEN-1:0]        RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP        = 32'h0000_0013;

  // Fetch control states.
  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,  // free to issue a request
    IF_WAIT  = 2'd1,  // one granted request outstanding
    IF_HALT  = 2'd2   // stopped after an exception entry until a redirect
  } if_state_e;

  // One instruction buffer entry as seen by decode.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [XLEN-1:0]        pc;
    logic                   misalign;
    logic                   fault;
  } if_entry_t;

  // What decode sees when the buffer is empty.
  function automatic if_entry_t empty_entry();
    return '{instr: INSTR_NOP, pc: '0, misalign: 1'b0, fault: 1'b0};
  endfunction

endpackage

// File: rtl/if_buf.sv
// Instruction buffer: synchronous FIFO of fetch entries with flush.
module if_buf
  import if_stage_pkg::*;
#(
  parameter int  BUF_DEPTH = 2,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  if_entry_t        entry_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  output if_entry_t        head_o
);

  if_entry_t        mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Pointer and occupancy update; flush wins over push and pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count_q alone says which entries are live.
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : empty_entry();

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the imem req/gnt/rvalid bus,
// buffers responses for decode and handles redirects and fetch exceptions.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic                   imem_req_o,
  output logic [XLEN-1:0]        imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [31:0]            imem_rdata_i,
  input  logic                   imem_err_i,
  output logic                   if_valid_o,
  input  logic                   id_ready_i,
  output logic [INSTR_WIDTH-1:0] if_instr_o,
  output logic [XLEN-1:0]        if_pc_o,
  output logic                   if_excp_misalign_o,
  output logic                   if_excp_fault_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;   // address held while a request waits for gnt
  logic [XLEN-1:0] out_pc_q, out_pc_d;       // PC of the granted, unreturned request
  logic            outst_q, outst_d;         // granted request not yet returned
  logic            pend_q, pend_d;           // request asserted but not yet granted
  logic            drop_q, drop_d;           // next response belongs to a squashed request
  logic            mis_pend_q, mis_pend_d;   // enqueue a misaligned-target entry next cycle
  logic [XLEN-1:0] mis_pc_q, mis_pc_d;

  logic             rsp_take, rsp_err, can_issue, gnt, stale_gnt;
  logic             buf_push;
  if_entry_t        push_entry, head;
  logic [CNT_W-1:0] count, occupancy;

  // Issue decision and bus drive; an in-flight response always has a reserved slot.
  always_comb begin
    rsp_take    = imem_rvalid_i && !drop_q && !redirect_i;
    rsp_err     = rsp_take && imem_err_i;
    occupancy   = count + CNT_W'(rsp_take);
    can_issue   = !rst && !redirect_i && !pend_q && !rsp_err &&
                  ((state_q == IF_FETCH) || ((state_q == IF_WAIT) && imem_rvalid_i)) &&
                  (occupancy < CNT_W'(BUF_DEPTH));
    imem_req_o  = !rst && (pend_q || can_issue);
    imem_addr_o = pend_q ? req_addr_q : pc_q;
    gnt         = imem_req_o && imem_gnt_i;
    // A pending request squashed by a redirect must not advance the PC when granted.
    stale_gnt   = gnt && pend_q && drop_q;
  end

  // Next-state logic; a redirect takes priority over everything else.
  always_comb begin
    outst_d    = gnt ? 1'b1 : (imem_rvalid_i ? 1'b0 : outst_q);
    pend_d     = imem_req_o && !imem_gnt_i;
    req_addr_d = can_issue ? pc_q : req_addr_q;
    out_pc_d   = gnt ? imem_addr_o : out_pc_q;
    mis_pend_d = 1'b0;
    mis_pc_d   = mis_pc_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    state_d    = state_q;
    if (redirect_i) begin
      pc_d   = redirect_pc_i;
      drop_d = outst_d || pend_d;
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_d    = IF_HALT;
        mis_pend_d = 1'b1;
        mis_pc_d   = redirect_pc_i;
      end else begin
        state_d = outst_d ? IF_WAIT : IF_FETCH;
      end
    end else begin
      if (gnt && !stale_gnt) pc_d = imem_addr_o + XLEN'(4);
      if (imem_rvalid_i && drop_q) drop_d = 1'b0;
      if (rsp_err || (state_q == IF_HALT)) state_d = IF_HALT;
      else if (gnt)                        state_d = IF_WAIT;
      else if ((state_q == IF_WAIT) && imem_rvalid_i) state_d = IF_FETCH;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      out_pc_q   <= '0;
      outst_q    <= 1'b0;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      mis_pend_q <= 1'b0;
      mis_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      out_pc_q   <= out_pc_d;
      outst_q    <= outst_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      mis_pend_q <= mis_pend_d;
      mis_pc_q   <= mis_pc_d;
    end
  end

  // Buffer write: misaligned-target marker or a kept memory response.
  always_comb begin
    buf_push = !redirect_i && (mis_pend_q || rsp_take);
    if (mis_pend_q) begin
      push_entry = '{instr: INSTR_NOP, pc: mis_pc_q, misalign: 1'b1, fault: 1'b0};
    end else begin
      push_entry = '{instr: imem_rdata_i, pc: out_pc_q, misalign: 1'b0, fault: imem_err_i};
    end
  end

  if_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (buf_push),
    .entry_i (push_entry),
    .pop_i   (id_ready_i),
    .count_o (count),
    .valid_o (if_valid_o),
    .head_o  (head)
  );

  assign if_instr_o         = head.instr;
  assign if_pc_o            = head.pc;
  assign if_excp_misalign_o = head.misalign;
  assign if_excp_fault_o    = head.fault;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a one-cycle-latency memory model returning
// instr = addr[31:0], with knobs for holding a response and injecting a fault.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   redirect_i;
  logic [XLEN-1:0]        redirect_pc_i;
  logic                   imem_req_o;
  logic [XLEN-1:0]        imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [31:0]            imem_rdata_i;
  logic                   imem_err_i;
  logic                   if_valid_o;
  logic                   id_ready_i;
  logic [INSTR_WIDTH-1:0] if_instr_o;
  logic [XLEN-1:0]        if_pc_o;
  logic                   if_excp_misalign_o;
  logic                   if_excp_fault_o;

  int checks = 0;
  int errors = 0;

  // Memory model state.
  logic            mem_pend = 1'b0;
  logic [XLEN-1:0] mem_addr = '0;
  logic            mem_hold = 1'b0;
  logic [XLEN-1:0] err_addr = '1;

  if_stage dut (
    .clk                (clk),
    .rst                (rst),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .imem_req_o         (imem_req_o),
    .imem_addr_o        (imem_addr_o),
    .imem_gnt_i         (imem_gnt_i),
    .imem_rvalid_i      (imem_rvalid_i),
    .imem_rdata_i       (imem_rdata_i),
    .imem_err_i         (imem_err_i),
    .if_valid_o         (if_valid_o),
    .id_ready_i         (id_ready_i),
    .if_instr_o         (if_instr_o),
    .if_pc_o            (if_pc_o),
    .if_excp_misalign_o (if_excp_misalign_o),
    .if_excp_fault_o    (if_excp_fault_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply this cycle's inputs (memory response comes from the model) and let them settle.
  task automatic drive(input logic g, input logic r, input logic rd, input logic [63:0] rpc);
    imem_gnt_i    = g;
    id_ready_i    = r;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_rvalid_i = mem_pend && !mem_hold;
    imem_rdata_i  = mem_addr[31:0];
    imem_err_i    = imem_rvalid_i && (mem_addr == err_addr);
    #1;
  endtask

  // Advance one clock; a granted request becomes next cycle's response.
  task automatic step();
    logic            nxt;
    logic [XLEN-1:0] nxta;
    nxt  = imem_req_o && imem_gnt_i;
    nxta = imem_addr_o;
    @(posedge clk);
    #1;
    if (!(mem_pend && mem_hold)) begin
      mem_pend = nxt;
      mem_addr = nxta;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    mem_pend = 1'b0;
    mem_hold = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_pend = 1'b0;
  endtask

  // Wait (bounded) for the next head entry with ready high, check it, and pop it.
  task automatic consume(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                         input logic mis, input logic flt);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0);
      if (if_valid_o) begin
        seen = 1'b1;
        check({tag, ".pc"}, if_pc_o, pc);
        check({tag, ".instr"}, if_instr_o, instr);
        check({tag, ".misalign"}, if_excp_misalign_o, mis);
        check({tag, ".fault"}, if_excp_fault_o, flt);
      end
      step();
    end
    if (!seen) check({tag, ".timeout_valid"}, if_valid_o, 1);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    check("rst.req", imem_req_o, 0);
    check("rst.valid", if_valid_o, 0);
    check("rst.instr", if_instr_o, 32'h0000_0013);
    check("rst.pc", if_pc_o, 0);
    check("rst.misalign", if_excp_misalign_o, 0);
    check("rst.fault", if_excp_fault_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with an always-granting memory.
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p1.req0", imem_req_o, 1);
    check("p1.addr0", imem_addr_o, 64'h8000_0000);
    check("p1.valid0", if_valid_o, 0);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p1.valid1", if_valid_o, 0);
    check("p1.addr1", imem_addr_o, 64'h8000_0004);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p1.valid2", if_valid_o, 1);
    check("p1.pc2", if_pc_o, 64'h8000_0000);
    check("p1.instr2", if_instr_o, 32'h8000_0000);
    step();
    consume("p1.a4", 64'h8000_0004, 32'h8000_0004, 0, 0);
    consume("p1.a8", 64'h8000_0008, 32'h8000_0008, 0, 0);
    consume("p1.ac", 64'h8000_000C, 32'h8000_000C, 0, 0);

    // Decode stalled: buffer fills to two, then requests stop.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    check("p2.req_full", imem_req_o, 0);
    check("p2.valid", if_valid_o, 1);
    check("p2.head", if_pc_o, 64'h8000_0000);
    consume("p2.a0", 64'h8000_0000, 32'h8000_0000, 0, 0);
    consume("p2.a4", 64'h8000_0004, 32'h8000_0004, 0, 0);
    consume("p2.a8", 64'h8000_0008, 32'h8000_0008, 0, 0);
    consume("p2.ac", 64'h8000_000C, 32'h8000_000C, 0, 0);

    // Redirect while a granted fetch is still outstanding.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    check("p3.req0", imem_req_o, 1);
    step();
    mem_hold = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 64'h8000_0100);
    check("p3.req_redir", imem_req_o, 0);
    step();
    mem_hold = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);
    check("p3.req_new", imem_req_o, 1);
    check("p3.addr_new", imem_addr_o, 64'h8000_0100);
    check("p3.valid_a", if_valid_o, 0);
    step();
    drive(1'b1, 1'b0, 1'b0, '0);
    check("p3.stale_dropped", if_valid_o, 0);
    step();
    consume("p3.t0", 64'h8000_0100, 32'h8000_0100, 0, 0);
    consume("p3.t4", 64'h8000_0104, 32'h8000_0104, 0, 0);

    // Misaligned redirect target.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    step();
    drive(1'b1, 1'b0, 1'b0, '0);
    step();
    drive(1'b1, 1'b0, 1'b1, 64'h8000_0102);
    check("p4.noreq_redir", imem_req_o, 0);
    step();
    drive(1'b1, 1'b0, 1'b0, '0);
    check("p4.noreq1", imem_req_o, 0);
    check("p4.flushed", if_valid_o, 0);
    step();
    drive(1'b1, 1'b0, 1'b0, '0);
    check("p4.noreq2", imem_req_o, 0);
    consume("p4.mis", 64'h8000_0102, 32'h0000_0013, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0);
      check("p4.halt_req", imem_req_o, 0);
      check("p4.halt_valid", if_valid_o, 0);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 64'h8000_0200);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p4.resume_req", imem_req_o, 1);
    check("p4.resume_addr", imem_addr_o, 64'h8000_0200);
    step();
    consume("p4.r0", 64'h8000_0200, 32'h8000_0200, 0, 0);
    consume("p4.r4", 64'h8000_0204, 32'h8000_0204, 0, 0);

    // Access fault on the response for 0x8000_0008.
    do_reset();
    err_addr = 64'h8000_0008;
    consume("p5.a0", 64'h8000_0000, 32'h8000_0000, 0, 0);
    consume("p5.a4", 64'h8000_0004, 32'h8000_0004, 0, 0);
    consume("p5.a8", 64'h8000_0008, 32'h8000_0008, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0);
      check("p5.halt_req", imem_req_o, 0);
      check("p5.halt_valid", if_valid_o, 0);
      step();
    end
    err_addr = '1;
    drive(1'b1, 1'b1, 1'b1, 64'h8000_0300);
    step();
    consume("p5.r0", 64'h8000_0300, 32'h8000_0300, 0, 0);

    // Grant held low for three cycles while a redirect arrives.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("p6.req0", imem_req_o, 1);
    check("p6.addr0", imem_addr_o, 64'h8000_0000);
    step();
    drive(1'b0, 1'b1, 1'b1, 64'h8000_0400);
    check("p6.req_redir", imem_req_o, 1);
    check("p6.addr_redir", imem_addr_o, 64'h8000_0000);
    step();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("p6.addr_hold", imem_addr_o, 64'h8000_0000);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p6.req_gnt", imem_req_o, 1);
    check("p6.addr_gnt", imem_addr_o, 64'h8000_0000);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p6.req_new", imem_req_o, 1);
    check("p6.addr_new", imem_addr_o, 64'h8000_0400);
    check("p6.valid_a", if_valid_o, 0);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p6.stale_dropped", if_valid_o, 0);
    step();
    consume("p6.t0", 64'h8000_0400, 32'h8000_0400, 0, 0);
    consume("p6.t4", 64'h8000_0404, 32'h8000_0404, 0, 0);

    // PC wraps around the top of the 64-bit address space.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p7.addr_top", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    check("p7.addr_wrap", imem_addr_o, 64'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
